uart_rx: RTL and testbench

Receive-only 8-bit UART, 8N1 frame, fixed baud rate; the receiving end of the link driven by the team's transmit-only UART.
- Samples the asynchronous serial line at mid-bit using a clocks-per-bit counter.
- Presents each received byte on a valid/accept handshake to downstream logic.
- Flags framing errors and overruns.

---
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 115 +++++++++++
 tb/tb_uart_rx.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops reset to RST_VAL so the output is well defined straight out of reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_nrst,
   input  logic i_d,
   output logic o_q
);

   logic meta;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         meta <= RST_VAL;
         o_q  <= RST_VAL;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Receive-only 8N1 UART: mid-bit sampling of a synchronized serial line,
// byte delivery on a valid/accept handshake, framing-error and overrun pulses.
module uart_rx #(
   parameter int unsigned SAMPLE = 16
) (
   input  logic       i_clk,
   input  logic       i_nrst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_accept,
   output logic       o_ferr,
   output logic       o_overrun
);

   localparam int unsigned HALF = SAMPLE / 2;
   localparam int unsigned CW   = $clog2(SAMPLE);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(SAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t          state;
   logic [CW-1:0]   count;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic            rxs;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .i_clk  (i_clk),
      .i_nrst (i_nrst),
      .i_d    (i_rx),
      .o_q    (rxs)
   );

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state     <= IDLE;
         count     <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         o_data    <= '0;
         o_valid   <= 1'b0;
         o_ferr    <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         o_ferr    <= 1'b0;
         o_overrun <= 1'b0;
         if (o_valid && i_accept)
            o_valid <= 1'b0;

         unique case (state)
            IDLE: begin
               count <= '0;
               if (!rxs)
                  state <= START;
            end
            START: begin
               if (count == HALF_LAST) begin
                  count   <= '0;
                  bit_idx <= '0;
                  state   <= rxs ? IDLE : DATA;
               end else begin
                  count <= count + CW'(1);
               end
            end
            DATA: begin
               if (count == BIT_LAST) begin
                  count   <= '0;
                  shift   <= {rxs, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= STOP;
               end else begin
                  count <= count + CW'(1);
               end
            end
            STOP: begin
               if (count == BIT_LAST) begin
                  count <= '0;
                  if (!rxs) begin
                     o_ferr <= 1'b1;
                     state  <= BREAK;
                  end else begin
                     // An accept in this same cycle frees the holding register,
                     // so the load below overrides the clear above.
                     if (o_valid && !i_accept) begin
                        o_overrun <= 1'b1;
                     end else begin
                        o_data  <= shift;
                        o_valid <= 1'b1;
                     end
                     state <= IDLE;
                  end
               end else begin
                  count <= count + CW'(1);
               end
            end
            BREAK: begin
               count <= '0;
               if (rxs)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (SAMPLE=4 and SAMPLE=8) driven with directed
// and random frames; observed events are compared with a frame-level event model.
module tb_uart_rx;

   localparam int EV_DEL  = 0;
   localparam int EV_FERR = 1;
   localparam int EV_OVR  = 2;

   typedef struct {
      int inst;
      int kind;
      int data;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       nrst;
   logic       rx    [2];
   logic       acc   [2];
   logic [7:0] data  [2];
   logic       valid [2];
   logic       ferr  [2];
   logic       ovr   [2];

   int  cyc   = 0;
   int  n_vec = 0;
   int  n_err = 0;
   ev_t exp_q[$];
   ev_t obs_q[$];
   logic       held [2];
   logic       pv   [2];
   logic       pacc [2];
   logic [7:0] pd   [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx #(.SAMPLE(4)) u_rx4 (
      .i_clk     (clk),
      .i_nrst    (nrst),
      .i_rx      (rx[0]),
      .o_data    (data[0]),
      .o_valid   (valid[0]),
      .i_accept  (acc[0]),
      .o_ferr    (ferr[0]),
      .o_overrun (ovr[0])
   );

   uart_rx #(.SAMPLE(8)) u_rx8 (
      .i_clk     (clk),
      .i_nrst    (nrst),
      .i_rx      (rx[1]),
      .o_data    (data[1]),
      .o_valid   (valid[1]),
      .i_accept  (acc[1]),
      .o_ferr    (ferr[1]),
      .o_overrun (ovr[1])
   );

   function automatic int samp(input int idx);
      return (idx != 0) ? 8 : 4;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic monitor_step();
      for (int i = 0; i < 2; i++) begin
         if (valid[i] && (!pv[i] || pacc[i]))
            obs_q.push_back('{i, EV_DEL, int'(data[i]), cyc});
         else if (valid[i])
            check($sformatf("hold%0d", i), data[i], pd[i]);
         if (ferr[i]) obs_q.push_back('{i, EV_FERR, 0, cyc});
         if (ovr[i])  obs_q.push_back('{i, EV_OVR, 0, cyc});
         pv[i]   = valid[i];
         pd[i]   = data[i];
         pacc[i] = acc[i];
      end
   endtask

   task automatic check_zero(input int i, input string tag);
      check($sformatf("%s_data%0d", tag, i),  data[i],  32'h0);
      check($sformatf("%s_valid%0d", tag, i), valid[i], 32'h0);
      check($sformatf("%s_ferr%0d", tag, i),  ferr[i],  32'h0);
      check($sformatf("%s_ovr%0d", tag, i),   ovr[i],   32'h0);
   endtask

   // Model: the outcome of a frame lands 2 (sync) + HALF + 9*SAMPLE + 1 cycles after the start edge.
   task automatic send_frame(input int idx, input logic [7:0] b, input logic stop_ok);
      int  s = samp(idx);
      ev_t e;
      e.inst = idx;
      e.cyc  = cyc + 2 + s / 2 + 9 * s + 1;
      e.data = 0;
      if (!stop_ok) begin
         e.kind = EV_FERR;
      end else if (held[idx]) begin
         e.kind = EV_OVR;
      end else begin
         e.kind    = EV_DEL;
         e.data    = int'(b);
         held[idx] = !acc[idx];
      end
      exp_q.push_back(e);
      rx[idx] = 1'b0;
      tick(s);
      for (int n = 0; n < 8; n++) begin
         rx[idx] = b[n];
         tick(s);
      end
      rx[idx] = stop_ok;
      tick(s);
   endtask

   task automatic glitch(input int idx, input int g);
      rx[idx] = 1'b0;
      tick(g);
      rx[idx] = 1'b1;
      tick(2 * samp(idx));
   endtask

   task automatic drain(input string tag);
      tick(20);
      for (int i = 0; i < 2; i++) begin
         ev_t e[$];
         ev_t o[$];
         foreach (exp_q[j]) if (exp_q[j].inst == i) e.push_back(exp_q[j]);
         foreach (obs_q[j]) if (obs_q[j].inst == i) o.push_back(obs_q[j]);
         check($sformatf("%s_nev%0d", tag, i), o.size(), e.size());
         for (int j = 0; j < e.size() && j < o.size(); j++) begin
            check($sformatf("%s_kind%0d_%0d", tag, i, j), o[j].kind, e[j].kind);
            check($sformatf("%s_data%0d_%0d", tag, i, j), o[j].data, e[j].data);
            check($sformatf("%s_cyc%0d_%0d", tag, i, j),  o[j].cyc,  e[j].cyc);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      logic [7:0] b;
      logic       ok;
      int         s;

      nrst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rx[i] = 1'b1; acc[i] = 1'b0; held[i] = 1'b0;
         pv[i] = 1'b0; pacc[i] = 1'b0; pd[i] = '0;
      end
      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
      join_none
      #2;
      check_zero(0, "rst");
      check_zero(1, "rst");
      tick(3);
      nrst = 1'b1;
      tick(5);

      // 1: byte held until accepted; timing checked through the event model
      send_frame(0, 8'hA5, 1'b1);
      tick(20);
      check("t1_valid", valid[0], 1'b1);
      check("t1_data", data[0], 8'hA5);
      acc[0] = 1'b1;
      tick(1);
      acc[0] = 1'b0;
      held[0] = 1'b0;
      check("t1_cleared", valid[0], 1'b0);
      drain("t1");

      // 2: back-to-back frames, zero idle bits
      acc[0] = 1'b1;
      send_frame(0, 8'h3C, 1'b1);
      send_frame(0, 8'hC3, 1'b1);
      drain("t2");

      // 3: short start glitch on the SAMPLE=8 instance
      acc[1] = 1'b1;
      glitch(1, 3);
      send_frame(1, 8'h55, 1'b1);
      drain("t3");

      // 4: bad stop followed by a held-low line
      send_frame(1, 8'h81, 1'b0);
      tick(40);
      rx[1] = 1'b1;
      tick(16);
      send_frame(1, 8'h12, 1'b1);
      drain("t4");

      // 5: overrun while the first byte is still held
      acc[0] = 1'b0;
      send_frame(0, 8'h11, 1'b1);
      send_frame(0, 8'h22, 1'b1);
      drain("t5");
      check("t5_valid", valid[0], 1'b1);
      check("t5_data", data[0], 8'h11);

      // 6: reset during data bit 4, with a byte still held
      b = 8'h6B;
      rx[0] = 1'b0;
      tick(4);
      for (int n = 0; n < 4; n++) begin
         rx[0] = b[n];
         tick(4);
      end
      rx[0] = b[4];
      tick(2);
      nrst = 1'b0;
      #1;
      check_zero(0, "t6");
      held[0] = 1'b0;
      rx[0] = 1'b1;
      tick(3);
      nrst = 1'b1;
      tick(12);
      acc[0] = 1'b1;
      send_frame(0, 8'hF0, 1'b1);
      drain("t6");

      // 7: accept coincides with the stop sample of the next good frame
      acc[0] = 1'b0;
      send_frame(0, 8'h9E, 1'b1);
      tick(3);
      held[0] = 1'b0;
      fork
         send_frame(0, 8'h4D, 1'b1);
         begin
            tick(40);
            acc[0] = 1'b1;
            tick(1);
            acc[0] = 1'b0;
         end
      join
      drain("t7");
      check("t7_data", data[0], 8'h4D);
      acc[0] = 1'b1;
      tick(1);
      held[0] = 1'b0;
      check("t7_cleared", valid[0], 1'b0);

      // random frames, glitches and framing errors on both instances
      for (int idx = 0; idx < 2; idx++) begin
         s = samp(idx);
         acc[idx] = 1'b1;
         for (int f = 0; f < 15; f++) begin
            if ($urandom_range(0, 9) == 0)
               glitch(idx, $urandom_range(1, s / 2));
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(idx, b, ok);
            if (!ok) begin
               tick($urandom_range(0, 40));
               rx[idx] = 1'b1;
               tick(s + $urandom_range(0, 5));
            end else if ($urandom_range(0, 1) != 0) begin
               tick($urandom_range(0, 2 * s));
            end
         end
         drain($sformatf("rnd%0d", idx));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
